// File: rtl/alu_types_pkg.sv
// Shared ALU types: opcode enum, data word and common widths.
package alu_types_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned ALU_OP_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

endpackage

// File: rtl/alu_resp_fifo.sv
// Synchronous result FIFO; head entry is visible whenever not empty.
module alu_resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 36
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    push,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic [W-1:0]            head_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop & ~empty;
  // A push into a full FIFO is still taken when the head leaves at the same edge.
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issues ALU requests from a register stage and returns tagged results in order.
module alu_issue_unit
  import alu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ALU_OP_W-1:0] req_op,
  input  word_t               req_a,
  input  word_t               req_b,
  input  logic [TAG_W-1:0]    req_tag,
  output logic [ALU_OP_W-1:0] alu_op,
  output word_t               alu_a,
  output word_t               alu_b,
  input  word_t               alu_out,
  output logic                resp_valid,
  input  logic                resp_ready,
  output word_t               resp_data,
  output logic [TAG_W-1:0]    resp_tag,
  output logic [WORD_W-1:0]   issue_cnt
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = WORD_W + TAG_W;

  logic               stage_valid;
  logic [TAG_W-1:0]   stage_tag;
  logic               accept;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;
  logic [OCC_W-1:0]   occupancy;

  // Reserve a FIFO slot for the staged op so its push can never be refused.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(stage_valid);
  assign req_ready = ~fifo_full & (occupancy < OCC_W'(DEPTH));
  assign accept    = req_valid & req_ready;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stage_valid <= 1'b0;
      stage_tag   <= '0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      issue_cnt   <= '0;
    end else if (accept) begin
      stage_valid <= 1'b1;
      stage_tag   <= req_tag;
      alu_op      <= req_op;
      alu_a       <= req_a;
      alu_b       <= req_b;
      issue_cnt   <= issue_cnt + WORD_W'(1);
    end else begin
      stage_valid <= 1'b0;
    end
  end

  alu_resp_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (stage_valid),
    .push_data ({alu_out, stage_tag}),
    .pop       (resp_ready),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign resp_valid            = ~fifo_empty;
  assign {resp_data, resp_tag} = head;

endmodule
